wav_dfi_phy_hs_resp: RTL and testbench

WAV_DFI_PHY_HS_RESP -- requirements
Module: wav_dfi_phy_hs_resp

---
 rtl/wav_dfi_phy_pkg.sv | 15 +
 rtl/wav_dfi_phy_hs_resp_if.sv | 37 +++
 rtl/wav_dfi_lp_resp.sv | 79 +++++++
 rtl/wav_dfi_phy_hs_resp.sv | 200 ++++++++++++++++++++
 tb/tb_wav_dfi_phy_hs_resp.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wav_dfi_phy_pkg.sv
// Shared FSM state types and default timing for the DFI PHY handshake responder.
package wav_dfi_phy_pkg;

    typedef enum logic [1:0] {HsIdle, HsWait, HsAck} hs_state_e;

    typedef enum logic [2:0] {PuIdle, PuPend, PuReq, PuHold, PuDrop} pu_state_e;

    localparam int unsigned WakeW = 6;

    localparam int unsigned LpAckDlyDef      = 2;
    localparam int unsigned CtrlupdAckDlyDef = 2;
    localparam int unsigned PhyupdHoldDef    = 16;
    localparam int unsigned TphyupdRespDef   = 32;

endpackage

// File: rtl/wav_dfi_phy_hs_resp_if.sv
// DFI low-power, ctrlupd and phyupd handshake bundle between the MC side and the PHY responder.
interface wav_dfi_phy_hs_resp_if;
    import wav_dfi_phy_pkg::*;

    logic             lp_ctrl_req;
    logic [WakeW-1:0] lp_ctrl_wakeup;
    logic             lp_ctrl_ack;
    logic             lp_data_req;
    logic [WakeW-1:0] lp_data_wakeup;
    logic             lp_data_ack;
    logic [WakeW-1:0] lp_ctrl_wakeup_q;
    logic [WakeW-1:0] lp_data_wakeup_q;
    logic             ctrlupd_req;
    logic             ctrlupd_ack;
    logic             phyupd_req;
    logic [1:0]       phyupd_type;
    logic             phyupd_ack;
    logic             upd_trig;
    logic [1:0]       upd_type_in;
    logic             upd_done;
    logic             upd_timeout;

    modport master (
        output lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, ctrlupd_req,
        output phyupd_ack, upd_trig, upd_type_in,
        input  lp_ctrl_ack, lp_data_ack, lp_ctrl_wakeup_q, lp_data_wakeup_q, ctrlupd_ack,
        input  phyupd_req, phyupd_type, upd_done, upd_timeout
    );

    modport slave (
        input  lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup, ctrlupd_req,
        input  phyupd_ack, upd_trig, upd_type_in,
        output lp_ctrl_ack, lp_data_ack, lp_ctrl_wakeup_q, lp_data_wakeup_q, ctrlupd_ack,
        output phyupd_req, phyupd_type, upd_done, upd_timeout
    );

endinterface

// File: rtl/wav_dfi_lp_resp.sv
// One DFI low-power request/ack channel: delayed ack, wakeup capture, abort on early req drop.
module wav_dfi_lp_resp
    import wav_dfi_phy_pkg::*;
#(
    parameter int unsigned AckDly = LpAckDlyDef
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req,
    input  logic [WakeW-1:0] wakeup,
    input  logic             accept_ok,
    output logic             ack,
    output logic [WakeW-1:0] wakeup_q,
    output logic             idle
);

    localparam int unsigned     CntW    = $clog2(AckDly + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(AckDly - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(AckDly);

    hs_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ack_d;
    logic [WakeW-1:0] wakeup_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_d    = ack;
        wakeup_d = wakeup_q;
        unique case (state_q)
            HsIdle: begin
                if (req && accept_ok) begin
                    state_d = HsWait;
                    cnt_d   = '0;
                end
            end
            HsWait: begin
                if (!req) begin
                    state_d = HsIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d  = HsAck;
                    ack_d    = 1'b1;
                    wakeup_d = wakeup;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HsAck: begin
                if (!req) begin
                    state_d = HsIdle;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = HsIdle;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= HsIdle;
            cnt_q    <= '0;
            ack      <= 1'b0;
            wakeup_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack      <= ack_d;
            wakeup_q <= wakeup_d;
        end
    end

    assign idle = (state_q == HsIdle);

endmodule

// File: rtl/wav_dfi_phy_hs_resp.sv
// DFI PHY-side handshake responder: two LP channels, MC ctrlupd and PHY-initiated phyupd.
module wav_dfi_phy_hs_resp
    import wav_dfi_phy_pkg::*;
#(
    parameter int unsigned LP_ACK_DLY      = LpAckDlyDef,
    parameter int unsigned CTRLUPD_ACK_DLY = CtrlupdAckDlyDef,
    parameter int unsigned PHYUPD_HOLD     = PhyupdHoldDef,
    parameter int unsigned TPHYUPD_RESP    = TphyupdRespDef
) (
    input logic                  clock,
    input logic                  reset,
    wav_dfi_phy_hs_resp_if.slave hs
);

    localparam int unsigned      CuW     = $clog2(CTRLUPD_ACK_DLY + 1);
    localparam logic [CuW-1:0]   CuLast  = CuW'(CTRLUPD_ACK_DLY - 1);
    localparam logic [CuW-1:0]   CuMax   = CuW'(CTRLUPD_ACK_DLY);
    localparam int unsigned      WcntW   = $clog2(TPHYUPD_RESP + 1);
    localparam logic [WcntW-1:0] WcntLst = WcntW'(TPHYUPD_RESP - 1);
    localparam logic [WcntW-1:0] WcntMax = WcntW'(TPHYUPD_RESP);
    localparam int unsigned      HcntW   = $clog2(PHYUPD_HOLD + 1);
    localparam logic [HcntW-1:0] HcntLst = HcntW'(PHYUPD_HOLD - 1);
    localparam logic [HcntW-1:0] HcntMax = HcntW'(PHYUPD_HOLD);

    logic lp_ctrl_idle, lp_data_idle;
    logic phy_free, phy_go, accept_ok;

    hs_state_e      cu_state_q, cu_state_d;
    logic [CuW-1:0] cu_cnt_q, cu_cnt_d;
    logic           cu_ack_q, cu_ack_d;

    pu_state_e        pu_state_q, pu_state_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic [HcntW-1:0] hcnt_q, hcnt_d;
    logic             pend_q, pend_d;
    logic [1:0]       pend_type_q, pend_type_d;
    logic             phyupd_req_q, phyupd_req_d;
    logic [1:0]       phyupd_type_q, phyupd_type_d;
    logic             upd_done_q, upd_done_d;
    logic             upd_timeout_q, upd_timeout_d;

    // PEND still admits MC requests, otherwise a held ctrlupd_req would deadlock PEND->REQ.
    // On the cycle the PHY update launches, it wins over new LP/ctrlupd requests.
    assign phy_free  = (pu_state_q == PuIdle) || (pu_state_q == PuPend);
    assign phy_go    = (pu_state_q == PuPend) && lp_ctrl_idle && lp_data_idle &&
                       (cu_state_q == HsIdle) && !hs.ctrlupd_req;
    assign accept_ok = phy_free && !phy_go;

    wav_dfi_lp_resp #(.AckDly(LP_ACK_DLY)) u_lp_ctrl (
        .clock     (clock),
        .reset     (reset),
        .req       (hs.lp_ctrl_req),
        .wakeup    (hs.lp_ctrl_wakeup),
        .accept_ok (accept_ok),
        .ack       (hs.lp_ctrl_ack),
        .wakeup_q  (hs.lp_ctrl_wakeup_q),
        .idle      (lp_ctrl_idle)
    );

    wav_dfi_lp_resp #(.AckDly(LP_ACK_DLY)) u_lp_data (
        .clock     (clock),
        .reset     (reset),
        .req       (hs.lp_data_req),
        .wakeup    (hs.lp_data_wakeup),
        .accept_ok (accept_ok),
        .ack       (hs.lp_data_ack),
        .wakeup_q  (hs.lp_data_wakeup_q),
        .idle      (lp_data_idle)
    );

    always_comb begin
        cu_state_d = cu_state_q;
        cu_cnt_d   = cu_cnt_q;
        cu_ack_d   = cu_ack_q;
        unique case (cu_state_q)
            HsIdle: begin
                if (hs.ctrlupd_req && accept_ok) begin
                    cu_state_d = HsWait;
                    cu_cnt_d   = '0;
                end
            end
            HsWait: begin
                if (!hs.ctrlupd_req) begin
                    cu_state_d = HsIdle;
                    cu_cnt_d   = '0;
                end else if (cu_cnt_q == CuLast) begin
                    cu_state_d = HsAck;
                    cu_ack_d   = 1'b1;
                end else if (cu_cnt_q != CuMax) begin
                    cu_cnt_d = cu_cnt_q + 1'b1;
                end
            end
            HsAck: begin
                if (!hs.ctrlupd_req) begin
                    cu_state_d = HsIdle;
                    cu_ack_d   = 1'b0;
                end
            end
            default: begin
                cu_state_d = HsIdle;
                cu_ack_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        pu_state_d    = pu_state_q;
        wcnt_d        = wcnt_q;
        hcnt_d        = hcnt_q;
        pend_d        = pend_q;
        pend_type_d   = pend_type_q;
        phyupd_req_d  = phyupd_req_q;
        phyupd_type_d = phyupd_type_q;
        upd_done_d    = 1'b0;
        upd_timeout_d = upd_timeout_q;
        unique case (pu_state_q)
            PuIdle: begin
                if (pend_q) pu_state_d = PuPend;
            end
            PuPend: begin
                if (phy_go) begin
                    pu_state_d    = PuReq;
                    phyupd_req_d  = 1'b1;
                    phyupd_type_d = pend_type_q;
                    wcnt_d        = '0;
                    pend_d        = 1'b0;
                end
            end
            PuReq: begin
                if (hs.phyupd_ack) begin
                    pu_state_d = PuHold;
                    hcnt_d     = '0;
                end else begin
                    if (wcnt_q != WcntMax) wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q >= WcntLst) upd_timeout_d = 1'b1;
                end
            end
            PuHold: begin
                if (hcnt_q == HcntLst) begin
                    pu_state_d   = PuDrop;
                    phyupd_req_d = 1'b0;
                end else if (hcnt_q != HcntMax) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            PuDrop: begin
                if (!hs.phyupd_ack) begin
                    pu_state_d = PuIdle;
                    upd_done_d = 1'b1;
                end
            end
            default: begin
                pu_state_d   = PuIdle;
                phyupd_req_d = 1'b0;
            end
        endcase
        // A new trigger overrides the clear on launch so back-to-back requests are not lost.
        if (hs.upd_trig) begin
            pend_d      = 1'b1;
            pend_type_d = hs.upd_type_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cu_state_q    <= HsIdle;
            cu_cnt_q      <= '0;
            cu_ack_q      <= 1'b0;
            pu_state_q    <= PuIdle;
            wcnt_q        <= '0;
            hcnt_q        <= '0;
            pend_q        <= 1'b0;
            pend_type_q   <= '0;
            phyupd_req_q  <= 1'b0;
            phyupd_type_q <= '0;
            upd_done_q    <= 1'b0;
            upd_timeout_q <= 1'b0;
        end else begin
            cu_state_q    <= cu_state_d;
            cu_cnt_q      <= cu_cnt_d;
            cu_ack_q      <= cu_ack_d;
            pu_state_q    <= pu_state_d;
            wcnt_q        <= wcnt_d;
            hcnt_q        <= hcnt_d;
            pend_q        <= pend_d;
            pend_type_q   <= pend_type_d;
            phyupd_req_q  <= phyupd_req_d;
            phyupd_type_q <= phyupd_type_d;
            upd_done_q    <= upd_done_d;
            upd_timeout_q <= upd_timeout_d;
        end
    end

    assign hs.ctrlupd_ack = cu_ack_q;
    assign hs.phyupd_req  = phyupd_req_q;
    assign hs.phyupd_type = phyupd_type_q;
    assign hs.upd_done    = upd_done_q;
    assign hs.upd_timeout = upd_timeout_q;

endmodule

// File: tb/tb_wav_dfi_phy_hs_resp.sv
// Scoreboard bench: directed handshake scenarios then random traffic against a timeline model.
module tb_wav_dfi_phy_hs_resp;

    localparam int LpD = 2;
    localparam int CuD = 2;
    localparam int HoldN = 16;
    localparam int TmoN = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    wav_dfi_phy_hs_resp_if hs_if ();

    wav_dfi_phy_hs_resp #(
        .LP_ACK_DLY      (LpD),
        .CTRLUPD_ACK_DLY (CuD),
        .PHYUPD_HOLD     (HoldN),
        .TPHYUPD_RESP    (TmoN)
    ) dut (
        .clock (clock),
        .reset (reset),
        .hs    (hs_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;
    logic [19:0] sb [$];

    // Model: each handshake is "age since accepted" (-1 when not waiting) plus an ack flag.
    // The PHY update is a phase number: 0 quiet, 1 queued, 2 asking, 3 holding, 4 releasing.
    int         lp_age [2] = '{-1, -1};
    bit         lp_ack [2] = '{0, 0};
    logic [5:0] lp_wq  [2] = '{6'd0, 6'd0};
    int         cu_age = -1;
    bit         cu_ack = 0;
    int         phase = 0;
    int         wait_n = 0;
    int         hold_n = 0;
    bit         pend = 0;
    logic [1:0] ptype = 2'd0;
    logic [1:0] m_type = 2'd0;
    bit         m_req = 0, m_done = 0, m_tmo = 0;

    task automatic hs_model(input bit req, input int dly, input bit allowed,
                            inout int age, inout bit ack, output bit fire);
        fire = 0;
        if (ack) begin
            if (!req) ack = 0;
        end else if (age >= 0) begin
            if (!req) age = -1;
            else if (age + 1 == dly) begin
                ack = 1; age = -1; fire = 1;
            end else age = age + 1;
        end else if (req && allowed) begin
            age = 0;
        end
    endtask

    task automatic model_step();
        bit         req_in [2];
        logic [5:0] wk [2];
        bit         free, go, busy, fire;
        int         a;
        bit         k;
        req_in[0] = hs_if.lp_ctrl_req;
        req_in[1] = hs_if.lp_data_req;
        wk[0] = hs_if.lp_ctrl_wakeup;
        wk[1] = hs_if.lp_data_wakeup;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                lp_age[i] = -1; lp_ack[i] = 0; lp_wq[i] = 6'd0;
            end
            cu_age = -1; cu_ack = 0; phase = 0; wait_n = 0; hold_n = 0;
            pend = 0; ptype = 2'd0; m_type = 2'd0; m_req = 0; m_done = 0; m_tmo = 0;
            return;
        end
        free = (phase <= 1);
        busy = lp_ack[0] || lp_ack[1] || lp_age[0] >= 0 || lp_age[1] >= 0 ||
               cu_ack || cu_age >= 0;
        go = (phase == 1) && !busy && !hs_if.ctrlupd_req;
        for (int i = 0; i < 2; i++) begin
            a = lp_age[i]; k = lp_ack[i];
            hs_model(req_in[i], LpD, free && !go, a, k, fire);
            lp_age[i] = a; lp_ack[i] = k;
            if (fire) lp_wq[i] = wk[i];
        end
        hs_model(hs_if.ctrlupd_req, CuD, free && !go, cu_age, cu_ack, fire);
        m_done = 0;
        case (phase)
            0: if (pend) phase = 1;
            1: if (go) begin
                phase = 2; m_req = 1; m_type = ptype; pend = 0; wait_n = 0;
            end
            2: if (hs_if.phyupd_ack) begin
                phase = 3; hold_n = 0;
            end else begin
                wait_n = wait_n + 1;
                if (wait_n >= TmoN) m_tmo = 1;
            end
            3: begin
                hold_n = hold_n + 1;
                if (hold_n == HoldN) begin
                    phase = 4; m_req = 0;
                end
            end
            4: if (!hs_if.phyupd_ack) begin
                phase = 0; m_done = 1;
            end
            default: phase = 0;
        endcase
        if (hs_if.upd_trig) begin
            pend = 1; ptype = hs_if.upd_type_in;
        end
    endtask

    function automatic logic [19:0] exp_vec();
        return {lp_ack[0], lp_ack[1], lp_wq[0], lp_wq[1], cu_ack, m_req, m_type, m_done, m_tmo};
    endfunction

    // Inputs are applied at the falling edge; the expected post-edge outputs are queued.
    task automatic tick();
        model_step();
        sb.push_back(exp_vec());
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [19:0] mon_exp, mon_act;
    initial begin
        forever begin
            @(posedge clock);
            #1;
            cycle++;
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                mon_act = {hs_if.lp_ctrl_ack, hs_if.lp_data_ack, hs_if.lp_ctrl_wakeup_q,
                           hs_if.lp_data_wakeup_q, hs_if.ctrlupd_ack, hs_if.phyupd_req,
                           hs_if.phyupd_type, hs_if.upd_done, hs_if.upd_timeout};
                n_tests++;
                if (mon_act !== mon_exp) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got %05h required %05h",
                             cycle, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        hs_if.lp_ctrl_req = 0; hs_if.lp_ctrl_wakeup = '0;
        hs_if.lp_data_req = 0; hs_if.lp_data_wakeup = '0;
        hs_if.ctrlupd_req = 0; hs_if.phyupd_ack = 0;
        hs_if.upd_trig = 0;    hs_if.upd_type_in = '0;
        reset = 1;
        run(3);
        reset = 0;
        run(2);

        // LP ctrl held 10 cycles with wakeup 5, then released
        hs_if.lp_ctrl_wakeup = 6'h05; hs_if.lp_ctrl_req = 1;
        run(10);
        hs_if.lp_ctrl_req = 0;
        run(3);

        // LP data single-cycle pulse aborts
        hs_if.lp_data_wakeup = 6'h2a; hs_if.lp_data_req = 1;
        run(1);
        hs_if.lp_data_req = 0;
        run(4);

        // Normal PHY update, type 01
        hs_if.upd_type_in = 2'b01; hs_if.upd_trig = 1;
        run(1);
        hs_if.upd_trig = 0;
        run(5);
        hs_if.phyupd_ack = 1;
        run(20);
        hs_if.phyupd_ack = 0;
        run(3);

        // Ack withheld past the response timeout
        hs_if.upd_type_in = 2'b10; hs_if.upd_trig = 1;
        run(1);
        hs_if.upd_trig = 0;
        run(42);
        hs_if.phyupd_ack = 1;
        run(18);
        hs_if.phyupd_ack = 0;
        run(3);
        reset = 1;
        run(1);
        reset = 0;
        run(1);

        // ctrlupd and PHY trigger in the same cycle: ctrlupd first
        hs_if.ctrlupd_req = 1; hs_if.upd_type_in = 2'b11; hs_if.upd_trig = 1;
        run(1);
        hs_if.upd_trig = 0;
        run(5);
        hs_if.ctrlupd_req = 0;
        run(6);
        hs_if.phyupd_ack = 1;
        run(18);
        hs_if.phyupd_ack = 0;
        run(3);

        // Reset while holding phyupd_req
        hs_if.upd_trig = 1;
        run(1);
        hs_if.upd_trig = 0;
        run(4);
        hs_if.phyupd_ack = 1;
        run(6);
        reset = 1;
        run(1);
        reset = 0; hs_if.phyupd_ack = 0;
        run(4);

        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(399) == 0);
            if ($urandom_range(7) == 0) hs_if.lp_ctrl_req = !hs_if.lp_ctrl_req;
            if ($urandom_range(9) == 0) hs_if.lp_data_req = !hs_if.lp_data_req;
            if ($urandom_range(11) == 0) hs_if.ctrlupd_req = !hs_if.ctrlupd_req;
            if ($urandom_range(5) == 0) hs_if.phyupd_ack = !hs_if.phyupd_ack;
            hs_if.lp_ctrl_wakeup = 6'($urandom);
            hs_if.lp_data_wakeup = 6'($urandom);
            hs_if.upd_trig = ($urandom_range(19) == 0);
            hs_if.upd_type_in = 2'($urandom);
            tick();
        end

        @(posedge clock);
        #3;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued entries, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
